// File: rtl/slave_split_responder.sv
// Split-capable memory slave: accepts one transfer, completes it SPLIT_LAT cycles later (ready pulse).
// Define SLAVE_SPLIT_RESPONDER_SPLIT_EN for split/bus-return handshake; otherwise plain wait states.
module slave_split_responder #(
  parameter int ADDR_W    = 12,
  parameter int DATA_W    = 8,
  parameter int SPLIT_LAT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sel,
  input  logic              valid,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              m_select,
  input  logic              split_grant,
  output logic [DATA_W-1:0] rdata,
  output logic              ready,
  output logic              split,
  output logic              split_req,
  output logic              split_owner
);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_WAIT  = 3'd2;
  localparam logic [2:0] ST_RESP  = 3'd4;
`ifdef SLAVE_SPLIT_RESPONDER_SPLIT_EN
  localparam logic [2:0] ST_SPLIT = 3'd1;
  localparam logic [2:0] ST_REQ   = 3'd3;
`endif

  localparam logic [7:0] CNT_INIT = 8'(SPLIT_LAT - 1);

  logic [2:0]        state_q, state_d;
  logic [7:0]        cnt_q, cnt_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              owner_q, owner_d;

  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

`ifndef SLAVE_SPLIT_RESPONDER_SPLIT_EN
  logic unused_split_grant;
  assign unused_split_grant = split_grant;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    owner_d = owner_q;
    case (state_q)
      ST_IDLE: begin
        if (sel && valid) begin
          we_d    = we;
          addr_d  = addr;
          wdata_d = wdata;
          owner_d = m_select;
          cnt_d   = CNT_INIT;
`ifdef SLAVE_SPLIT_RESPONDER_SPLIT_EN
          state_d = ST_SPLIT;
`else
          state_d = ST_WAIT;
`endif
        end
      end
`ifdef SLAVE_SPLIT_RESPONDER_SPLIT_EN
      ST_SPLIT: state_d = ST_WAIT;
      ST_REQ: begin
        if (split_grant) state_d = ST_RESP;
      end
`endif
      ST_WAIT: begin
        if (cnt_q == 8'd0) begin
`ifdef SLAVE_SPLIT_RESPONDER_SPLIT_EN
          state_d = ST_REQ;
`else
          state_d = ST_RESP;
`endif
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
        owner_d = 1'b0;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      owner_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      owner_q <= owner_d;
    end
  end

  // Write lands on the RESP edge only, so a reset earlier in the transfer drops it.
  always_ff @(posedge clk) begin
    if (state_q == ST_RESP && we_q) mem[addr_q] <= wdata_q;
  end

  assign ready       = (state_q == ST_RESP);
  assign rdata       = (state_q == ST_RESP && !we_q) ? mem[addr_q] : '0;
  assign split_owner = owner_q;
`ifdef SLAVE_SPLIT_RESPONDER_SPLIT_EN
  assign split     = (state_q == ST_SPLIT);
  assign split_req = (state_q == ST_REQ);
`else
  assign split     = 1'b0;
  assign split_req = 1'b0;
`endif

endmodule

// File: tb/tb_slave_split_responder.sv
// Directed bench for slave_split_responder (SPLIT_LAT=4), both split and wait-state builds.
module tb_slave_split_responder;
  localparam int LAT = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sel = 1'b0, valid = 1'b0, we = 1'b0, m_select = 1'b0, split_grant = 1'b0;
  logic [11:0] addr = '0;
  logic [7:0]  wdata = '0;
  logic [7:0]  rdata;
  logic        ready, split, split_req, split_owner;

  int n_assert = 0;
  int n_fail   = 0;

  slave_split_responder #(.ADDR_W(12), .DATA_W(8), .SPLIT_LAT(LAT)) dut (
    .clk(clk), .rst(rst), .sel(sel), .valid(valid), .we(we), .addr(addr), .wdata(wdata),
    .m_select(m_select), .split_grant(split_grant), .rdata(rdata), .ready(ready),
    .split(split), .split_req(split_req), .split_owner(split_owner)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_rdata"}, rdata, 0);
    chk({tag, "_ready"}, ready, 0);
    chk({tag, "_split"}, split, 0);
    chk({tag, "_split_req"}, split_req, 0);
    chk({tag, "_owner"}, split_owner, 0);
  endtask

  // Cycle 0 is the accept cycle; t_gnt is the cycle split_grant is driven (split build),
  // t_intr a cycle with an intruding write, t_spur a cycle with a stray grant pulse.
  task automatic run_txn(input string tag, input logic t_we, input logic [11:0] t_addr,
                         input logic [7:0] t_wdata, input logic t_msel, input int t_gnt,
                         input int t_intr, input int t_spur, input logic [7:0] t_exp);
    int rdy_c;
    logic e_rdy, e_split, e_req, e_own;
    logic [7:0] e_rd;
`ifdef SLAVE_SPLIT_RESPONDER_SPLIT_EN
    rdy_c = t_gnt + 1;
`else
    rdy_c = LAT + 1;
`endif
    sel = 1'b1; valid = 1'b1; we = t_we; addr = t_addr; wdata = t_wdata;
    m_select = t_msel; split_grant = 1'b0;
    chk({tag, "_c0_ready"}, ready, 0);
    chk({tag, "_c0_owner"}, split_owner, 0);
    for (int c = 1; c <= rdy_c + 1; c++) begin
      step();
      if (c == t_intr) begin
        sel = 1'b1; valid = 1'b1; we = 1'b1; addr = 12'h010; wdata = 8'hFF;
      end else begin
        sel = 1'b0; valid = 1'b0;
      end
      m_select    = ~t_msel;
      split_grant = (c == t_gnt) || (c == t_spur);
      e_rdy = (c == rdy_c);
`ifdef SLAVE_SPLIT_RESPONDER_SPLIT_EN
      e_split = (c == 1);
      e_req   = (c >= LAT + 2) && (c <= t_gnt);
`else
      e_split = 1'b0;
      e_req   = 1'b0;
`endif
      e_own = (c <= rdy_c) ? t_msel : 1'b0;
      e_rd  = (e_rdy && !t_we) ? t_exp : 8'h00;
      chk($sformatf("%s_c%0d_ready", tag, c), ready, e_rdy);
      chk($sformatf("%s_c%0d_split", tag, c), split, e_split);
      chk($sformatf("%s_c%0d_split_req", tag, c), split_req, e_req);
      chk($sformatf("%s_c%0d_owner", tag, c), split_owner, e_own);
      chk($sformatf("%s_c%0d_rdata", tag, c), rdata, e_rd);
    end
    sel = 1'b0; valid = 1'b0; split_grant = 1'b0;
  endtask

  initial begin
    #3;
    chk_all_zero("reset");
    step(); step();
    rst = 1'b0;
    step();
    chk_all_zero("idle");

    // write 0x5A @0x010, immediate grant, stray grant in WAIT
    run_txn("wr5a", 1'b1, 12'h010, 8'h5A, 1'b0, LAT + 2, -1, 3, 8'h00);
    // back-to-back read, grant delayed to cycle 9, intruding write of 0xFF at cycle 3
    run_txn("rd_dly", 1'b0, 12'h010, 8'h00, 1'b1, 9, 3, -1, 8'h5A);
    run_txn("rd_chk", 1'b0, 12'h010, 8'h00, 1'b0, LAT + 2, -1, -1, 8'h5A);

    // reset mid-write must drop the write
    run_txn("wr11", 1'b1, 12'h020, 8'h11, 1'b1, LAT + 2, -1, -1, 8'h00);
    sel = 1'b1; valid = 1'b1; we = 1'b1; addr = 12'h020; wdata = 8'h33; m_select = 1'b1;
    step();
    sel = 1'b0; valid = 1'b0;
    step(); step();
    chk("pre_rst_owner", split_owner, 1);
    rst = 1'b1;
    #1;
    chk_all_zero("async_rst");
    step();
    rst = 1'b0;
    step();
    chk_all_zero("post_rst");
    run_txn("rd20", 1'b0, 12'h020, 8'h00, 1'b0, LAT + 2, -1, -1, 8'h11);

    // top address
    run_txn("wrtop", 1'b1, 12'hFFF, 8'hA5, 1'b1, LAT + 3, -1, -1, 8'h00);
    run_txn("rdtop", 1'b0, 12'hFFF, 8'h00, 1'b1, LAT + 2, -1, -1, 8'hA5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
